dmux8way16_buf: RTL

- Write-side counterpart to the 8-way 16-bit selector: distributes one 16-bit input stream across eight registered output lanes (a..h).
- Each lane holds its word and a valid flag until the downstream consumer acknowledges it.
- Lane is chosen by an explicit select or by an internal round-robin pointer.
- Sits between a single producer (ALU/bus write port) and eight consumers (register slots, peripheral ports).

---
 rtl/dmux8way16_buf_pkg.sv | 33 +++
 rtl/dmux8way16_buf_lane.sv | 41 ++++
 rtl/dmux8way16_buf.sv | 113 +++++++++++
 3 files changed

// File: rtl/dmux8way16_buf_pkg.sv
// Shared constants for the 8-way 16-bit distributor and its selector counterpart.
// Holds lane count, select/count widths, lane index constants and a popcount helper.
package dmux8way16_buf_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 4;

    // Lane indices, shared with the read-side selector
    localparam int unsigned LANE_A = 0;
    localparam int unsigned LANE_B = 1;
    localparam int unsigned LANE_C = 2;
    localparam int unsigned LANE_D = 3;
    localparam int unsigned LANE_E = 4;
    localparam int unsigned LANE_F = 5;
    localparam int unsigned LANE_G = 6;
    localparam int unsigned LANE_H = 7;

    typedef logic [LANES-1:0] lane_mask_t;
    typedef logic [SEL_W-1:0] lane_sel_t;
    typedef logic [CNT_W-1:0] lane_cnt_t;

    // Number of set bits in a lane mask
    function automatic lane_cnt_t popcount(input lane_mask_t v);
        lane_cnt_t n;
        n = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dmux8way16_buf_lane.sv
// Single output lane: WIDTH-bit holding register plus a valid flag.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   wr_en       - load wr_data and set valid
//   wr_data     - word to load
//   ack         - consumer takes the word; clears valid unless reloaded this cycle
//   data        - held word (kept after ack)
//   valid       - lane holds an unacknowledged word
module dmux8way16_buf_lane #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // Data register only changes on a write, so it retains its value past an ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (wr_en) begin
            data <= wr_data;
        end
    end

    // Write wins over ack so a same-cycle ack+write keeps the lane occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid <= 1'b1;
        end else if (ack) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dmux8way16_buf.sv
// Distributes one WIDTH-bit producer stream across eight registered lanes (a..h).
// Lane chosen by in_sel or by an internal round-robin pointer (auto_sel=1).
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   in, in_valid   - producer word and its valid
//   in_sel         - explicit lane select (0=a .. 7=h)
//   auto_sel       - 1: use next_sel pointer, 0: use in_sel
//   in_ready       - combinational: selected lane is free or being acked
//   a..h           - lane data registers
//   lane_valid     - per-lane occupancy (bit0=a .. bit7=h)
//   lane_ack       - per-lane consumer acknowledge
//   next_sel       - round-robin pointer
//   count          - number of occupied lanes
//   full, empty    - count == 8 / count == 0
module dmux8way16_buf
    import dmux8way16_buf_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       in_sel,
    input  logic             auto_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [7:0]       lane_valid,
    input  logic [7:0]       lane_ack,
    output logic [2:0]       next_sel,
    output logic [3:0]       count,
    output logic             full,
    output logic             empty
);

    lane_sel_t  esel;
    logic       accept;
    lane_mask_t wr_en;
    lane_mask_t valid_nxt;
    lane_cnt_t  count_nxt;
    logic [WIDTH-1:0] lane_data [LANES];

    // Effective select, ready and per-lane write enables
    always_comb begin
        esel     = auto_sel ? next_sel : in_sel;
        in_ready = ~lane_valid[esel] | lane_ack[esel];
        accept   = in_valid & in_ready;
        wr_en    = '0;
        if (accept) begin
            wr_en[esel] = 1'b1;
        end
    end

    // Occupancy after this edge; ack on an empty lane drops out via the AND
    always_comb begin
        valid_nxt = (lane_valid & ~lane_ack) | wr_en;
        count_nxt = popcount(valid_nxt);
    end

    // Lane storage
    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        dmux8way16_buf_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[i]),
            .wr_data (in),
            .ack     (lane_ack[i]),
            .data    (lane_data[i]),
            .valid   (lane_valid[i])
        );
    end

    assign a = lane_data[LANE_A];
    assign b = lane_data[LANE_B];
    assign c = lane_data[LANE_C];
    assign d = lane_data[LANE_D];
    assign e = lane_data[LANE_E];
    assign f = lane_data[LANE_F];
    assign g = lane_data[LANE_G];
    assign h = lane_data[LANE_H];

    // Round-robin pointer: advances only on auto-mode accepts, wraps naturally at 3 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_sel <= '0;
        end else if (accept && auto_sel) begin
            next_sel <= next_sel + SEL_W'(1);
        end
    end

    // Occupancy count and flags, registered alongside the lane valids
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(LANES));
            empty <= (count_nxt == '0);
        end
    end

endmodule
